// File: rtl/clk_div_ratio_ctrl.sv
// rtl/clk_div_ratio_ctrl.sv - prescale-to-ratio controller with glitch-safe divider ratio swaps
//
// Purpose: maps a UART-style prescale (4/8/16/32) to the integer divider's ratio and
// drives the divider clock enable. A ratio change while running quiesces the divider,
// swaps the ratio, then restarts it after a guard window.
//
// Ports:
//   i_ref_clk      reference clock (also the divider clock)
//   i_rst_n        synchronous active-low reset
//   i_enable       divider enable request
//   i_cfg_valid    prescale offered this cycle
//   i_cfg_prescale requested prescale (legal: 4, 8, 16, 32)
//   o_cfg_ready    config accepted when high together with i_cfg_valid
//   o_cfg_err      one-cycle pulse after an illegal prescale was accepted and dropped
//   o_busy         ratio swap in progress
//   o_div_ratio    division ratio to the divider
//   o_clk_en       clock enable to the divider
module clk_div_ratio_ctrl #(
  parameter int BASE_RATIO    = 32,
  parameter int DEFAULT_RATIO = 1,
  parameter int GUARD_CYCLES  = 4
) (
  input  logic       i_ref_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic       i_cfg_valid,
  input  logic [5:0] i_cfg_prescale,
  output logic       o_cfg_ready,
  output logic       o_cfg_err,
  output logic       o_busy,
  output logic [7:0] o_div_ratio,
  output logic       o_clk_en
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_QUIESCE,
    ST_UPDATE,
    ST_RESTART
  } state_t;

  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ratio_q, ratio_d;
  logic [7:0] pend_q, pend_d;
  logic       clk_en_q, clk_en_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  logic       accept;
  logic       legal;
  logic [7:0] mapped;

  always_comb begin
    legal  = 1'b1;
    mapped = ratio_q;
    case (i_cfg_prescale)
      6'd32:   mapped = 8'(BASE_RATIO / 32);
      6'd16:   mapped = 8'(BASE_RATIO / 16);
      6'd8:    mapped = 8'(BASE_RATIO / 8);
      6'd4:    mapped = 8'(BASE_RATIO / 4);
      default: legal  = 1'b0;
    endcase
  end

  assign accept = i_cfg_valid & ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    err_d   = accept & ~legal;

    case (state_q)
      ST_IDLE: begin
        // Divider is stopped, so the ratio can be loaded without a guard window.
        if (accept && legal) ratio_d = mapped;
        if (i_enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!i_enable) begin
          // Stopping wins over a simultaneous change: load directly on the way to IDLE.
          state_d = ST_IDLE;
          if (accept && legal) ratio_d = mapped;
        end else if (accept && legal && (mapped != ratio_q)) begin
          pend_d  = mapped;
          cnt_d   = GUARD_LOAD;
          state_d = ST_QUIESCE;
        end
      end
      ST_QUIESCE: begin
        if (!i_enable) begin
          ratio_d = pend_q;
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_UPDATE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_UPDATE: begin
        ratio_d = pend_q;
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = GUARD_LOAD;
          state_d = ST_RESTART;
        end
      end
      ST_RESTART: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'd0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    clk_en_d = (state_d == ST_RUN);
    ready_d  = (state_d == ST_RUN) || (state_d == ST_IDLE);
    busy_d   = ~ready_d;
  end

  always_ff @(posedge i_ref_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      ratio_q  <= 8'(DEFAULT_RATIO);
      pend_q   <= 8'd0;
      clk_en_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign o_cfg_ready = ready_q;
  assign o_cfg_err   = err_q;
  assign o_busy      = busy_q;
  assign o_div_ratio = ratio_q;
  assign o_clk_en    = clk_en_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// tb/tb_clk_div_ratio_ctrl.sv - scoreboard bench for clk_div_ratio_ctrl
module tb_clk_div_ratio_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       cfg_valid;
  logic [5:0] cfg_prescale;
  logic       cfg_ready;
  logic       cfg_err;
  logic       busy;
  logic [7:0] div_ratio;
  logic       clk_en;

  always #5 clk = ~clk;

  clk_div_ratio_ctrl #(
    .BASE_RATIO(32),
    .DEFAULT_RATIO(1),
    .GUARD_CYCLES(4)
  ) dut (
    .i_ref_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(enable),
    .i_cfg_valid(cfg_valid),
    .i_cfg_prescale(cfg_prescale),
    .o_cfg_ready(cfg_ready),
    .o_cfg_err(cfg_err),
    .o_busy(busy),
    .o_div_ratio(div_ratio),
    .o_clk_en(clk_en)
  );

  typedef struct packed {
    logic [7:0] ratio;
    logic       clk_en;
    logic       ready;
    logic       err;
    logic       busy;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Monitor: each registered output sample is compared against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string t;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      a = '{ratio: div_ratio, clk_en: clk_en, ready: cfg_ready, err: cfg_err, busy: busy};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got ratio=%0d clk_en=%0b ready=%0b err=%0b busy=%0b, expected ratio=%0d clk_en=%0b ready=%0b err=%0b busy=%0b",
                 t, a.ratio, a.clk_en, a.ready, a.err, a.busy,
                 e.ratio, e.clk_en, e.ready, e.err, e.busy);
      end
    end
  end

  // Apply inputs for one edge, then queue the outputs expected after that edge.
  task automatic cyc(input string tag, input bit rn, input bit en, input bit v,
                     input logic [5:0] p, input logic [7:0] r, input bit ce,
                     input bit rdy, input bit err, input bit bsy);
    rst_n        = rn;
    enable       = en;
    cfg_valid    = v;
    cfg_prescale = p;
    @(posedge clk);
    #1;
    sb_q.push_back('{ratio: r, clk_en: ce, ready: rdy, err: err, busy: bsy});
    tag_q.push_back(tag);
  endtask

  // Full guarded ratio change from RUN with GUARD_CYCLES = 4; optionally keeps
  // offering a different prescale while busy, which must be ignored.
  task automatic do_change(input string tag, input logic [5:0] p,
                           input logic [7:0] old_r, input logic [7:0] new_r,
                           input bit hold_valid);
    cyc({tag, "_accept"}, 1, 1, 1, p, old_r, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      cyc({tag, "_quiesce"}, 1, 1, hold_valid, 6'd32, old_r, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      cyc({tag, "_restart"}, 1, 1, hold_valid, 6'd32, new_r, 0, 0, 0, 1);
    cyc({tag, "_run"}, 1, 1, hold_valid, 6'd32, new_r, 1, 1, 0, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    cfg_valid    = 1'b0;
    cfg_prescale = 6'd0;
    @(negedge clk);

    // Reset
    cyc("reset", 0, 0, 0, 6'd0, 8'd1, 0, 1, 0, 0);

    // Config in IDLE loads directly, then enable
    cyc("idle_cfg",  1, 0, 1, 6'd8, 8'd4, 0, 1, 0, 0);
    cyc("idle_hold", 1, 0, 0, 6'd0, 8'd4, 0, 1, 0, 0);
    cyc("enable",    1, 1, 0, 6'd0, 8'd4, 1, 1, 0, 0);

    // Guarded change while running, valid held during busy
    do_change("run_chg", 6'd16, 8'd4, 8'd2, 1'b1);
    cyc("run_idle_in", 1, 1, 0, 6'd0, 8'd2, 1, 1, 0, 0);

    // Illegal prescale pulses err once; equal ratio is a no-op
    cyc("illegal",   1, 1, 1, 6'd12, 8'd2, 1, 1, 1, 0);
    cyc("err_clear", 1, 1, 0, 6'd0,  8'd2, 1, 1, 0, 0);
    cyc("noop",      1, 1, 1, 6'd16, 8'd2, 1, 1, 0, 0);
    cyc("noop_hold", 1, 1, 0, 6'd0,  8'd2, 1, 1, 0, 0);

    // Disable during QUIESCE loads the pending ratio and goes IDLE
    cyc("abort_acc",  1, 1, 1, 6'd4, 8'd2, 0, 0, 0, 1);
    cyc("abort_q",    1, 1, 0, 6'd0, 8'd2, 0, 0, 0, 1);
    cyc("abort_idle", 1, 0, 0, 6'd0, 8'd8, 0, 1, 0, 0);
    cyc("abort_en",   1, 1, 0, 6'd0, 8'd8, 1, 1, 0, 0);

    // Reset during RESTART returns everything to reset values
    cyc("rr_acc", 1, 1, 1, 6'd16, 8'd8, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc("rr_quiesce", 1, 1, 0, 6'd0, 8'd8, 0, 0, 0, 1);
    cyc("rr_restart", 1, 1, 0, 6'd0, 8'd2, 0, 0, 0, 1);
    cyc("rr_restart", 1, 1, 0, 6'd0, 8'd2, 0, 0, 0, 1);
    cyc("rr_reset",   0, 1, 0, 6'd0, 8'd1, 0, 1, 0, 0);
    cyc("rr_post",    1, 0, 0, 6'd0, 8'd1, 0, 1, 0, 0);

    // Disable on the same edge as a changing config: direct load to IDLE
    cyc("off_en",  1, 1, 0, 6'd0, 8'd1, 1, 1, 0, 0);
    cyc("off_cfg", 1, 0, 1, 6'd8, 8'd4, 0, 1, 0, 0);

    // Sweep all legal prescales while running
    cyc("sweep_en", 1, 1, 0, 6'd0, 8'd4, 1, 1, 0, 0);
    do_change("sweep32", 6'd32, 8'd4, 8'd1, 1'b0);
    do_change("sweep16", 6'd16, 8'd1, 8'd2, 1'b0);
    do_change("sweep8",  6'd8,  8'd2, 8'd4, 1'b0);
    do_change("sweep4",  6'd4,  8'd4, 8'd8, 1'b0);
    cyc("sweep_end", 1, 1, 0, 6'd0, 8'd8, 1, 1, 0, 0);

    // Let the monitor drain the scoreboard, bounded
    begin
      int budget;
      budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (sb_q.size() > 0) begin
        miscompares++;
        $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
